// File: rtl/nv_nvdla_sdp_mrdma_pkg.sv
// Shared definitions for the second-generation SDP memory-read DMA:
// FSM states, request payload layout and parameter legality.
package nv_nvdla_sdp_mrdma_pkg;

  typedef enum logic [1:0] {
    MRDMA_IDLE  = 2'd0,
    MRDMA_RUN   = 2'd1,
    MRDMA_DRAIN = 2'd2
  } mrdma_state_e;

  // Request payload is {size-1, addr}; the size field sits directly above the address.
  localparam int REQ_SIZE_W   = 4;
  localparam int REQ_ADDR_LSB = 0;

  function automatic int req_size_lsb(input int aw);
    return aw;
  endfunction

  function automatic bit mrdma_params_ok(input int max_burst, input int cq_depth,
                                         input int ch_per_surf, input int atom_bytes);
    return (max_burst >= 1) && (max_burst <= 16) && (cq_depth >= max_burst) &&
           (ch_per_surf >= 1) && ((ch_per_surf & (ch_per_surf - 1)) == 0) &&
           (atom_bytes >= 1);
  endfunction

endpackage

// File: rtl/nv_nvdla_sdp_mrdma_gen2_walk.sv
// Surface/line/segment address walker: produces one burst request per load into
// a registered request slot, gated by the credit available for its size.
module nv_nvdla_sdp_mrdma_gen2_walk
  import nv_nvdla_sdp_mrdma_pkg::*;
#(
  parameter int AW          = 64,
  parameter int ATOM_BYTES  = 32,
  parameter int MAX_BURST   = 8,
  parameter int CQ_DEPTH    = 128,
  parameter int CH_PER_SURF = 8,
  parameter int OW          = $clog2(CQ_DEPTH + 1),
  parameter int SZ_W        = $clog2(MAX_BURST + 1)
) (
  input  logic                     nvdla_core_clk,
  input  logic                     nvdla_core_rstn,
  input  logic                     start,
  input  logic                     en,
  input  logic [AW-1:0]            base_addr,
  input  logic [AW-1:0]            line_stride,
  input  logic [AW-1:0]            surf_stride,
  input  logic [12:0]              width,
  input  logic [12:0]              height,
  input  logic [12:0]              channel,
  input  logic [OW-1:0]            outstanding_nxt,
  input  logic                     req_ready,
  output logic                     req_valid,
  output logic [AW+REQ_SIZE_W-1:0] req_pd,
  output logic [SZ_W-1:0]          req_size,
  output logic                     last_req_acc
);

  localparam int SEG_BYTES = MAX_BURST * ATOM_BYTES;
  localparam int CH_SH     = $clog2(CH_PER_SURF);
  localparam int SIZE_LSB  = req_size_lsb(AW);

  logic [AW-1:0] ls_r, ss_r, pos_addr, pos_line_base, pos_surf_base;
  logic [13:0]   atoms_r, pos_rem;
  logic [12:0]   height_r, pos_line, pos_surf;
  logic          pos_more;

  logic [AW-1:0]   k_ls, k_ss, c_addr, c_line_base, c_surf_base, n_addr, n_line_base, n_surf_base;
  logic [13:0]     k_atoms, c_rem, n_rem;
  logic [12:0]     k_height, c_line, c_surf, n_line, n_surf;
  logic [SZ_W-1:0] c_size;
  logic            n_more, credit_ok, load;

  // Current request comes straight from the registers on start so it issues next cycle.
  always_comb begin
    k_ls     = start ? line_stride : ls_r;
    k_ss     = start ? surf_stride : ss_r;
    k_atoms  = start ? ({1'b0, width} + 14'd1) : atoms_r;
    k_height = start ? height : height_r;
    if (start) begin
      c_addr      = base_addr;
      c_line_base = base_addr;
      c_surf_base = base_addr;
      c_rem       = {1'b0, width} + 14'd1;
      c_line      = height;
      c_surf      = channel >> CH_SH;
    end else begin
      c_addr      = pos_addr;
      c_line_base = pos_line_base;
      c_surf_base = pos_surf_base;
      c_rem       = pos_rem;
      c_line      = pos_line;
      c_surf      = pos_surf;
    end
    c_size = (c_rem > 14'(MAX_BURST)) ? SZ_W'(MAX_BURST) : c_rem[SZ_W-1:0];

    n_addr      = c_addr;
    n_line_base = c_line_base;
    n_surf_base = c_surf_base;
    n_rem       = c_rem;
    n_line      = c_line;
    n_surf      = c_surf;
    n_more      = 1'b1;
    if (c_rem > 14'(MAX_BURST)) begin
      n_addr = c_addr + AW'(SEG_BYTES);
      n_rem  = c_rem - 14'(MAX_BURST);
    end else if (c_line != 13'd0) begin
      n_line_base = c_line_base + k_ls;
      n_addr      = c_line_base + k_ls;
      n_rem       = k_atoms;
      n_line      = c_line - 13'd1;
    end else if (c_surf != 13'd0) begin
      n_surf_base = c_surf_base + k_ss;
      n_line_base = c_surf_base + k_ss;
      n_addr      = c_surf_base + k_ss;
      n_rem       = k_atoms;
      n_line      = k_height;
      n_surf      = c_surf - 13'd1;
    end else begin
      n_more = 1'b0;
    end
  end

  assign credit_ok    = ({1'b0, outstanding_nxt} + (OW+1)'(c_size)) <= (OW+1)'(CQ_DEPTH);
  assign load         = start | (en & pos_more & (~req_valid | req_ready) & credit_ok);
  assign last_req_acc = req_valid & req_ready & ~pos_more;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      req_valid <= 1'b0;
      req_pd    <= '0;
      req_size  <= '0;
      pos_more  <= 1'b0;
    end else if (load) begin
      req_valid                       <= 1'b1;
      req_pd[REQ_ADDR_LSB +: AW]      <= c_addr;
      req_pd[SIZE_LSB +: REQ_SIZE_W]  <= REQ_SIZE_W'(c_size - SZ_W'(1));
      req_size                        <= c_size;
      pos_more                        <= n_more;
    end else if (req_ready) begin
      req_valid <= 1'b0;
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (start) begin
      ls_r     <= line_stride;
      ss_r     <= surf_stride;
      atoms_r  <= {1'b0, width} + 14'd1;
      height_r <= height;
    end
    if (load) begin
      pos_addr      <= n_addr;
      pos_line_base <= n_line_base;
      pos_surf_base <= n_surf_base;
      pos_rem       <= n_rem;
      pos_line      <= n_line;
      pos_surf      <= n_surf;
    end
  end

endmodule

// File: rtl/nv_nvdla_sdp_mrdma_gen2.sv
// SDP memory-read DMA (gen2): layer FSM, outstanding-atom credit, MCIF/CVIF
// request steering, response pass-through to the cmux and the stall counter.
module nv_nvdla_sdp_mrdma_gen2
  import nv_nvdla_sdp_mrdma_pkg::*;
#(
  parameter int AW          = 64,
  parameter int DW          = 512,
  parameter int ATOM_BYTES  = 32,
  parameter int MAX_BURST   = 8,
  parameter int CQ_DEPTH    = 128,
  parameter int CH_PER_SURF = 8
) (
  input  logic                     nvdla_core_clk,
  input  logic                     nvdla_core_rstn,
  input  logic                     reg2dp_op_en,
  input  logic                     reg2dp_src_ram_type,
  input  logic [AW-1:0]            reg2dp_src_base_addr,
  input  logic [AW-1:0]            reg2dp_src_line_stride,
  input  logic [AW-1:0]            reg2dp_src_surface_stride,
  input  logic [12:0]              reg2dp_width,
  input  logic [12:0]              reg2dp_height,
  input  logic [12:0]              reg2dp_channel,
  input  logic                     reg2dp_perf_dma_en,
  output logic                     sdp2mcif_rd_req_valid,
  input  logic                     sdp2mcif_rd_req_ready,
  output logic [AW+3:0]            sdp2mcif_rd_req_pd,
  output logic                     sdp2cvif_rd_req_valid,
  input  logic                     sdp2cvif_rd_req_ready,
  output logic [AW+3:0]            sdp2cvif_rd_req_pd,
  input  logic                     mcif2sdp_rd_rsp_valid,
  output logic                     mcif2sdp_rd_rsp_ready,
  input  logic [DW-1:0]            mcif2sdp_rd_rsp_pd,
  input  logic                     cvif2sdp_rd_rsp_valid,
  output logic                     cvif2sdp_rd_rsp_ready,
  input  logic [DW-1:0]            cvif2sdp_rd_rsp_pd,
  output logic                     sdp2mcif_rd_cdt_lat_fifo_pop,
  output logic                     sdp2cvif_rd_cdt_lat_fifo_pop,
  output logic                     sdp_mrdma2cmux_valid,
  input  logic                     sdp_mrdma2cmux_ready,
  output logic [DW-1:0]            sdp_mrdma2cmux_pd,
  output logic                     dp2reg_done,
  output logic [31:0]              dp2reg_mrdma_stall
);

  localparam int OW   = $clog2(CQ_DEPTH + 1);
  localparam int SZ_W = $clog2(MAX_BURST + 1);

  if (!mrdma_params_ok(MAX_BURST, CQ_DEPTH, CH_PER_SURF, ATOM_BYTES)) begin : g_bad_params
    $error("nv_nvdla_sdp_mrdma_gen2: illegal MAX_BURST/CQ_DEPTH/CH_PER_SURF/ATOM_BYTES");
  end

  mrdma_state_e         state;
  logic                 ram_type_r, perf_en_r, op_load, active;
  logic [OW-1:0]        outstanding, outstanding_nxt;
  logic                 req_valid, sel_req_ready, req_acc, last_req_acc;
  logic [AW+3:0]        req_pd;
  logic [SZ_W-1:0]      req_size;
  logic                 sel_rsp_valid, beat_acc;
  logic [DW-1:0]        sel_rsp_pd;
  logic                 mcif_pop_p1, cvif_pop_p1;

  assign op_load       = reg2dp_op_en & (state == MRDMA_IDLE);
  assign active        = (state == MRDMA_RUN) | (state == MRDMA_DRAIN);
  assign sel_req_ready = ram_type_r ? sdp2mcif_rd_req_ready : sdp2cvif_rd_req_ready;
  assign req_acc       = req_valid & sel_req_ready;
  assign sel_rsp_valid = ram_type_r ? mcif2sdp_rd_rsp_valid : cvif2sdp_rd_rsp_valid;
  assign sel_rsp_pd    = ram_type_r ? mcif2sdp_rd_rsp_pd : cvif2sdp_rd_rsp_pd;
  assign beat_acc      = sel_rsp_valid & sdp_mrdma2cmux_ready & active;

  // Net credit change when a request and a beat are accepted together.
  assign outstanding_nxt = outstanding + (req_acc ? OW'(req_size) : OW'(0)) - OW'(beat_acc);

  nv_nvdla_sdp_mrdma_gen2_walk #(
    .AW(AW), .ATOM_BYTES(ATOM_BYTES), .MAX_BURST(MAX_BURST),
    .CQ_DEPTH(CQ_DEPTH), .CH_PER_SURF(CH_PER_SURF), .OW(OW), .SZ_W(SZ_W)
  ) u_walk (
    .nvdla_core_clk  (nvdla_core_clk),
    .nvdla_core_rstn (nvdla_core_rstn),
    .start           (op_load),
    .en              (state == MRDMA_RUN),
    .base_addr       (reg2dp_src_base_addr),
    .line_stride     (reg2dp_src_line_stride),
    .surf_stride     (reg2dp_src_surface_stride),
    .width           (reg2dp_width),
    .height          (reg2dp_height),
    .channel         (reg2dp_channel),
    .outstanding_nxt (outstanding_nxt),
    .req_ready       (sel_req_ready),
    .req_valid       (req_valid),
    .req_pd          (req_pd),
    .req_size        (req_size),
    .last_req_acc    (last_req_acc)
  );

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state              <= MRDMA_IDLE;
      ram_type_r         <= 1'b0;
      perf_en_r          <= 1'b0;
      outstanding        <= '0;
      dp2reg_done        <= 1'b0;
      dp2reg_mrdma_stall <= '0;
      mcif_pop_p1        <= 1'b0;
      cvif_pop_p1        <= 1'b0;
    end else begin
      dp2reg_done <= 1'b0;
      mcif_pop_p1 <= beat_acc & ram_type_r;
      cvif_pop_p1 <= beat_acc & ~ram_type_r;
      outstanding <= op_load ? '0 : outstanding_nxt;
      if (op_load)
        dp2reg_mrdma_stall <= '0;
      else if (perf_en_r & req_valid & ~sel_req_ready & (dp2reg_mrdma_stall != 32'hFFFF_FFFF))
        dp2reg_mrdma_stall <= dp2reg_mrdma_stall + 32'd1;
      case (state)
        MRDMA_IDLE: if (reg2dp_op_en) begin
          state      <= MRDMA_RUN;
          ram_type_r <= reg2dp_src_ram_type;
          perf_en_r  <= reg2dp_perf_dma_en;
        end
        MRDMA_RUN: if (last_req_acc) state <= MRDMA_DRAIN;
        MRDMA_DRAIN: if (outstanding_nxt == '0) begin
          state       <= MRDMA_IDLE;
          dp2reg_done <= 1'b1;
        end
        default: state <= MRDMA_IDLE;
      endcase
    end
  end

  assign sdp2mcif_rd_req_valid        = req_valid & ram_type_r;
  assign sdp2cvif_rd_req_valid        = req_valid & ~ram_type_r;
  assign sdp2mcif_rd_req_pd           = ram_type_r ? req_pd : '0;
  assign sdp2cvif_rd_req_pd           = ram_type_r ? '0 : req_pd;
  assign mcif2sdp_rd_rsp_ready        = sdp_mrdma2cmux_ready & active & ram_type_r;
  assign cvif2sdp_rd_rsp_ready        = sdp_mrdma2cmux_ready & active & ~ram_type_r;
  assign sdp2mcif_rd_cdt_lat_fifo_pop = mcif_pop_p1;
  assign sdp2cvif_rd_cdt_lat_fifo_pop = cvif_pop_p1;
  assign sdp_mrdma2cmux_valid         = sel_rsp_valid & active;
  assign sdp_mrdma2cmux_pd            = active ? sel_rsp_pd : '0;

endmodule

// File: tb/tb_nv_nvdla_sdp_mrdma_gen2.sv
// Directed bench for nv_nvdla_sdp_mrdma_gen2 with request and response scoreboards.
module tb_nv_nvdla_sdp_mrdma_gen2;

  localparam int AW = 64, DW = 64, AB = 32, MB = 8, CQ = 16, CPS = 8;

  logic          clk = 1'b0, rst_n;
  logic          op_en, ram_type, perf_en;
  logic [AW-1:0] base, lstride, sstride;
  logic [12:0]   width, height, channel;
  logic          mcif_req_valid, mcif_req_ready, cvif_req_valid, cvif_req_ready;
  logic [AW+3:0] mcif_req_pd, cvif_req_pd;
  logic          mcif_rsp_valid, mcif_rsp_ready, cvif_rsp_valid, cvif_rsp_ready;
  logic [DW-1:0] mcif_rsp_pd, cvif_rsp_pd, cmux_pd;
  logic          mcif_pop, cvif_pop, cmux_valid, cmux_ready, done;
  logic [31:0]   stall;

  int n_assert = 0, n_fail = 0, done_cnt = 0, iss_atoms = 0, beats_acc = 0;
  logic [AW+3:0] exp_req_q[$];
  logic [DW-1:0] exp_dq[$];

  always #5 clk = ~clk;

  nv_nvdla_sdp_mrdma_gen2 #(.AW(AW), .DW(DW), .ATOM_BYTES(AB), .MAX_BURST(MB),
                            .CQ_DEPTH(CQ), .CH_PER_SURF(CPS)) dut (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rst_n),
    .reg2dp_op_en(op_en), .reg2dp_src_ram_type(ram_type),
    .reg2dp_src_base_addr(base), .reg2dp_src_line_stride(lstride),
    .reg2dp_src_surface_stride(sstride),
    .reg2dp_width(width), .reg2dp_height(height), .reg2dp_channel(channel),
    .reg2dp_perf_dma_en(perf_en),
    .sdp2mcif_rd_req_valid(mcif_req_valid), .sdp2mcif_rd_req_ready(mcif_req_ready),
    .sdp2mcif_rd_req_pd(mcif_req_pd),
    .sdp2cvif_rd_req_valid(cvif_req_valid), .sdp2cvif_rd_req_ready(cvif_req_ready),
    .sdp2cvif_rd_req_pd(cvif_req_pd),
    .mcif2sdp_rd_rsp_valid(mcif_rsp_valid), .mcif2sdp_rd_rsp_ready(mcif_rsp_ready),
    .mcif2sdp_rd_rsp_pd(mcif_rsp_pd),
    .cvif2sdp_rd_rsp_valid(cvif_rsp_valid), .cvif2sdp_rd_rsp_ready(cvif_rsp_ready),
    .cvif2sdp_rd_rsp_pd(cvif_rsp_pd),
    .sdp2mcif_rd_cdt_lat_fifo_pop(mcif_pop), .sdp2cvif_rd_cdt_lat_fifo_pop(cvif_pop),
    .sdp_mrdma2cmux_valid(cmux_valid), .sdp_mrdma2cmux_ready(cmux_ready),
    .sdp_mrdma2cmux_pd(cmux_pd),
    .dp2reg_done(done), .dp2reg_mrdma_stall(stall)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mon_req(input logic [AW+3:0] pd);
    chk("req_expected", 128'(exp_req_q.size() != 0), 128'(1));
    if (exp_req_q.size() != 0) chk("req_pd", 128'(pd), 128'(exp_req_q.pop_front()));
    iss_atoms += int'(pd[AW+3:AW]) + 1;
  endtask

  // Handshakes are judged at the negedge; inputs only change just after posedge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mcif_req_valid && mcif_req_ready) mon_req(mcif_req_pd);
      if (cvif_req_valid && cvif_req_ready) mon_req(cvif_req_pd);
      if (cmux_valid && cmux_ready) begin
        chk("cmux_expected", 128'(exp_dq.size() != 0), 128'(1));
        if (exp_dq.size() != 0) chk("cmux_pd", 128'(cmux_pd), 128'(exp_dq.pop_front()));
        beats_acc++;
      end
      if (done) done_cnt++;
    end
  end

  task automatic start_layer(input bit rt, input logic [AW-1:0] b, input logic [AW-1:0] ls,
                             input logic [AW-1:0] ss, input int w, input int h, input int c,
                             input bit perf);
    ram_type = rt; base = b; lstride = ls; sstride = ss; perf_en = perf;
    width = 13'(w); height = 13'(h); channel = 13'(c);
    for (int s = 0; s <= c / CPS; s++)
      for (int l = 0; l <= h; l++)
        for (int a = 0; a <= w; a += MB) begin
          int sz;
          sz = (w + 1 - a > MB) ? MB : w + 1 - a;
          exp_req_q.push_back({4'(sz - 1), b + 64'(s) * ss + 64'(l) * ls + 64'(a / MB) * 64'(MB * AB)});
        end
    iss_atoms = 0; beats_acc = 0;
    op_en = 1'b1;
    tick();
    op_en = 1'b0;
  endtask

  task automatic beat(input bit rt, input logic [DW-1:0] d);
    bit ok, acc;
    ok = 0; acc = 0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (iss_atoms > beats_acc) ok = 1;
      @(posedge clk); #1;
    end
    chk("beat_credit_wait", 128'(ok), 128'(1));
    exp_dq.push_back(d);
    mcif_rsp_valid = 1'b1; cvif_rsp_valid = 1'b1;
    mcif_rsp_pd = rt ? d : ~d; cvif_rsp_pd = rt ? ~d : d;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      if (rt ? mcif_rsp_ready : cvif_rsp_ready) begin
        acc = 1;
        chk("other_rsp_ready", 128'(rt ? cvif_rsp_ready : mcif_rsp_ready), 128'(0));
      end
      @(posedge clk); #1;
    end
    mcif_rsp_valid = 1'b0; cvif_rsp_valid = 1'b0;
    chk("beat_accepted", 128'(acc), 128'(1));
    chk("pop_selected", 128'(rt ? mcif_pop : cvif_pop), 128'(1));
    chk("pop_other", 128'(rt ? cvif_pop : mcif_pop), 128'(0));
  endtask

  task automatic done_check(input string tag);
    chk({tag, "_done_hi"}, 128'(done), 128'(1));
    tick();
    chk({tag, "_done_lo"}, 128'(done), 128'(0));
  endtask

  task automatic outputs_zero(input string tag);
    chk({tag, "_mreq_v"}, 128'(mcif_req_valid), 128'(0));
    chk({tag, "_creq_v"}, 128'(cvif_req_valid), 128'(0));
    chk({tag, "_mreq_pd"}, 128'(mcif_req_pd), 128'(0));
    chk({tag, "_creq_pd"}, 128'(cvif_req_pd), 128'(0));
    chk({tag, "_rsp_rdy"}, 128'({mcif_rsp_ready, cvif_rsp_ready}), 128'(0));
    chk({tag, "_pops"}, 128'({mcif_pop, cvif_pop}), 128'(0));
    chk({tag, "_cmux_v"}, 128'(cmux_valid), 128'(0));
    chk({tag, "_cmux_pd"}, 128'(cmux_pd), 128'(0));
    chk({tag, "_done"}, 128'(done), 128'(0));
    chk({tag, "_stall"}, 128'(stall), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    rst_n = 1'b0; op_en = 1'b0; ram_type = 1'b0; perf_en = 1'b0;
    base = '0; lstride = '0; sstride = '0; width = '0; height = '0; channel = '0;
    mcif_req_ready = 1'b1; cvif_req_ready = 1'b1; cmux_ready = 1'b1;
    mcif_rsp_valid = 1'b0; cvif_rsp_valid = 1'b0; mcif_rsp_pd = '0; cvif_rsp_pd = '0;
    repeat (3) tick();
    outputs_zero("reset");
    rst_n = 1'b1;
    repeat (2) tick();

    // Single-beat layer on MCIF
    start_layer(1'b1, 64'h1000, 64'h100, 64'h10000, 0, 0, 7, 1'b0);
    chk("t1_req_valid", 128'(mcif_req_valid), 128'(1));
    chk("t1_req_pd", 128'(mcif_req_pd), 128'({4'h0, 64'h1000}));
    chk("t1_cvif_valid", 128'(cvif_req_valid), 128'(0));
    beat(1'b1, 64'hA5A5_0001);
    done_check("t1");

    // Segmenting: 20 atoms per line, two lines
    start_layer(1'b1, 64'h2000, 64'h1000, 64'h10000, 19, 1, 7, 1'b0);
    for (int i = 0; i < 39; i++) beat(1'b1, 64'hB000 + 64'(i));
    chk("t2_done_early", 128'(done), 128'(0));
    beat(1'b1, 64'hB0FF);
    done_check("t2");
    chk("t2_req_q_empty", 128'(exp_req_q.size()), 128'(0));

    // Credit limit: 20 single-atom requests against 16 credits
    start_layer(1'b1, 64'h4000, 64'h40, 64'h10000, 0, 19, 7, 1'b0);
    repeat (20) tick();
    chk("t3_issued_at_limit", 128'(iss_atoms), 128'(16));
    chk("t3_valid_dropped", 128'(mcif_req_valid), 128'(0));
    beat(1'b1, 64'hC000);
    chk("t3_valid_resumed", 128'(mcif_req_valid), 128'(1));
    for (int i = 1; i < 20; i++) beat(1'b1, 64'hC000 + 64'(i));
    done_check("t3");
    chk("t3_issued_total", 128'(iss_atoms), 128'(20));

    // CVIF select with stall counting
    cvif_req_ready = 1'b0;
    start_layer(1'b0, 64'h5000, 64'h100, 64'h10000, 0, 0, 7, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("t4_mcif_valid", 128'(mcif_req_valid), 128'(0));
      chk("t4_cvif_valid", 128'(cvif_req_valid), 128'(1));
      tick();
    end
    chk("t4_cvif_pd", 128'(cvif_req_pd), 128'({4'h0, 64'h5000}));
    cvif_req_ready = 1'b1;
    tick();
    chk("t4_stall", 128'(stall), 128'(5));
    beat(1'b0, 64'hD000);
    done_check("t4");
    chk("t4_stall_hold", 128'(stall), 128'(5));

    // Request accept (size 4) coincident with a beat accept
    start_layer(1'b1, 64'h6000, 64'h1000, 64'h10000, 11, 0, 7, 1'b0);
    tick();
    mcif_req_ready = 1'b0;
    chk("t5_req2_valid", 128'(mcif_req_valid), 128'(1));
    chk("t5_req2_pd", 128'(mcif_req_pd), 128'({4'h3, 64'h6100}));
    exp_dq.push_back(64'hE000);
    mcif_rsp_valid = 1'b1; mcif_rsp_pd = 64'hE000; mcif_req_ready = 1'b1;
    @(negedge clk);
    chk("t5_req_hs", 128'(mcif_req_valid & mcif_req_ready), 128'(1));
    chk("t5_rsp_hs", 128'(mcif_rsp_ready), 128'(1));
    @(posedge clk); #1;
    mcif_rsp_valid = 1'b0;
    for (int i = 1; i < 11; i++) beat(1'b1, 64'hE000 + 64'(i));
    chk("t5_done_early", 128'(done), 128'(0));
    beat(1'b1, 64'hE0FF);
    done_check("t5");

    // Reset while draining with 3 beats outstanding
    start_layer(1'b1, 64'h7000, 64'h100, 64'h10000, 3, 0, 7, 1'b0);
    tick();
    beat(1'b1, 64'hF000);
    #2 rst_n = 1'b0;
    #1;
    outputs_zero("t6_rst");
    d0 = done_cnt;
    repeat (3) tick();
    chk("t6_no_done", 128'(done_cnt), 128'(d0));
    chk("t6_req_q_empty", 128'(exp_req_q.size()), 128'(0));
    rst_n = 1'b1;
    tick();
    start_layer(1'b1, 64'h8000, 64'h100, 64'h10000, 0, 0, 7, 1'b0);
    chk("t6_new_req_pd", 128'(mcif_req_pd), 128'({4'h0, 64'h8000}));
    beat(1'b1, 64'h8888);
    done_check("t6");

    repeat (3) tick();
    chk("total_done_pulses", 128'(done_cnt), 128'(6));
    chk("rsp_q_empty", 128'(exp_dq.size()), 128'(0));
    chk("req_q_empty", 128'(exp_req_q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
